// File: rtl/tile_hash_generator.sv
// Streaming CRC-16/CCITT-FALSE signature generator for graphics tiles.
// One byte per cycle; the hash of a frame is presented the cycle after its last byte.
module tile_hash_generator #(
    parameter logic [15:0] POLY    = 16'h1021,
    parameter logic [15:0] INIT    = 16'hFFFF,
    parameter logic [15:0] XOR_OUT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    input  logic        data_last,
    output logic        hash_valid,
    output logic [15:0] hash_out
);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;
    logic [15:0] hash_out_reg;
    logic        hash_valid_reg;

    // Eight unrolled shift/reduce stages process a whole byte in one cycle.
    logic [15:0] stage [0:8];

    assign stage[0] = crc_reg ^ {data_in, 8'h00};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_crc_stage
            assign stage[gi+1] = stage[gi][15] ? ({stage[gi][14:0], 1'b0} ^ POLY)
                                               :  {stage[gi][14:0], 1'b0};
        end
    endgenerate

    assign crc_next = stage[8];

    // The running CRC is reloaded with INIT as the last byte is absorbed, so the
    // next accepted byte always starts a fresh frame without extra state.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_reg        <= INIT;
            hash_out_reg   <= 16'h0000;
            hash_valid_reg <= 1'b0;
        end else if (data_valid) begin
            if (data_last) begin
                crc_reg        <= INIT;
                hash_out_reg   <= crc_next ^ XOR_OUT;
                hash_valid_reg <= 1'b1;
            end else begin
                crc_reg        <= crc_next;
                hash_valid_reg <= 1'b0;
            end
        end
    end

    assign hash_valid = hash_valid_reg;
    assign hash_out   = hash_out_reg;

endmodule

// File: tb/tb_tile_hash_generator.sv
// Scoreboard bench for tile_hash_generator: the driver queues expected hashes,
// a reference monitor tracks the expected output levels and a checker compares every cycle.
module tb_tile_hash_generator;

    localparam logic [15:0] POLY = 16'h1021;

    logic        clk;
    logic        rst;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        data_last;
    logic        hash_valid;
    logic [15:0] hash_out;

    int          checks;
    int          errors;
    logic [15:0] sb [$];
    logic        exp_valid;
    logic [15:0] exp_out;
    string       test_name;
    logic        done;

    tile_hash_generator dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_last  (data_last),
        .hash_valid (hash_valid),
        .hash_out   (hash_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial reference: feed each data bit into the feedback term.
    function automatic logic [15:0] ref_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    function automatic logic [15:0] ref_tile(input logic [7:0] t [16]);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 16; i++) c = ref_byte(c, t[i]);
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last, input logic [15:0] exp_hash);
        @(posedge clk); #1;
        if (last) sb.push_back(exp_hash);
        data_valid = 1'b1;
        data_in    = b;
        data_last  = last;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data_valid = 1'b0;
            data_in    = 8'($urandom);
            data_last  = 1'($urandom);
        end
    endtask

    task automatic send_check_string();
        for (int i = 0; i < 9; i++)
            send_byte(8'h31 + 8'(i), i == 8, 16'h29B1);
    endtask

    // gap_mask bit i inserts one idle cycle before byte i.
    task automatic send_tile(input logic [7:0] t [16], input logic [15:0] gap_mask);
        logic [15:0] h;
        h = ref_tile(t);
        for (int i = 0; i < 16; i++) begin
            if (gap_mask[i]) idle(1);
            send_byte(t[i], i == 15, h);
        end
    endtask

    // Reference monitor: expected output levels after each clock edge.
    initial begin
        exp_valid = 1'b0;
        exp_out   = 16'h0000;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_valid = 1'b0;
                exp_out   = 16'h0000;
            end else if (data_valid) begin
                if (data_last) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_underflow [%s]: frame completed with no expected hash queued", test_name);
                    end else begin
                        exp_out = sb.pop_front();
                    end
                    exp_valid = 1'b1;
                end else begin
                    exp_valid = 1'b0;
                end
            end
        end
    end

    // Checker: compare outputs away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (done) break;
            checks++;
            if (hash_valid !== exp_valid || hash_out !== exp_out) begin
                errors++;
                $display("FAIL hash_output [%s] t=%0t: got valid=%b hash=%h, expected valid=%b hash=%h",
                         test_name, $time, hash_valid, hash_out, exp_valid, exp_out);
            end else if (hash_valid && $time > 0) begin
                $display("check [%s] t=%0t: hash_valid=1 hash_out=%h", test_name, $time, hash_out);
            end
        end
    end

    initial begin
        logic [7:0] t_zero [16];
        logic [7:0] t_ff   [16];
        logic [7:0] t_inc  [16];
        logic [7:0] t_rnd  [16];
        t_rnd = '{8'h3C, 8'hA7, 8'h5E, 8'h01, 8'hF2, 8'h9B, 8'h44, 8'hD8,
                  8'h6E, 8'h10, 8'hC3, 8'h7F, 8'h88, 8'h2A, 8'hB5, 8'hE9};
        for (int i = 0; i < 16; i++) begin
            t_zero[i] = 8'h00;
            t_ff[i]   = 8'hFF;
            t_inc[i]  = 8'(i);
        end

        checks     = 0;
        errors     = 0;
        done       = 1'b0;
        test_name  = "reset";
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        data_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        test_name = "check_string";
        send_check_string();
        idle(5);

        test_name = "one_byte_00_41";
        send_byte(8'h00, 1'b1, 16'hE1F0);
        send_byte(8'h41, 1'b1, 16'hB915);
        idle(3);

        test_name = "tile_zero";   send_tile(t_zero, 16'h0000); idle(5);
        test_name = "tile_ff";     send_tile(t_ff,   16'h0000); idle(5);
        test_name = "tile_inc";    send_tile(t_inc,  16'h0000); idle(5);
        test_name = "tile_random"; send_tile(t_rnd,  16'h0000); idle(5);

        test_name = "tile_rnd_gaps";
        send_tile(t_rnd, 16'b0100_0010_0001_0110);
        idle(4);

        test_name = "back_to_back";
        send_check_string();
        send_check_string();
        idle(2);

        test_name = "mid_frame_reset";
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0, 16'h0000);
        @(posedge clk); #1;
        rst        = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hAA;
        data_last  = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        send_check_string();
        idle(5);

        test_name = "drain";
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected hashes left, required 0", sb.size());
        end
        done = 1'b1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
